// File: rtl/ahb_apb_pkg.sv
// Shared definitions for the AHB-Lite to APB4 bridge: FSM state encoding and strobe decode.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package ahb_apb_pkg;

    // One-hot FSM state encoding
    localparam logic [3:0] ST_IDLE   = 4'b0001;
    localparam logic [3:0] ST_WDATA  = 4'b0010;
    localparam logic [3:0] ST_SETUP  = 4'b0100;
    localparam logic [3:0] ST_ACCESS = 4'b1000;

    // Widest strobe vector the decode supports (64-bit data bus)
    localparam int MAX_STRB = 8;

    // Byte-lane mask for a write: 2^size lanes starting at the size-aligned
    // byte offset; sizes wider than the bus light every lane.
    function automatic logic [MAX_STRB-1:0] strb_gen(input logic [2:0] size,
                                                     input logic [2:0] addr_lsbs,
                                                     input int         sz);
        int          nbytes;
        int          lg;
        int          width;
        int          off;
        logic [15:0] m;
        nbytes = sz / 8;
        lg     = (nbytes == 8) ? 3 : 2;
        if (int'(size) > lg) begin
            m = 16'((1 << nbytes) - 1);
        end else begin
            width = 1 << size;
            off   = int'(addr_lsbs) & (nbytes - 1) & ~(width - 1);
            m     = 16'(((1 << width) - 1) << off);
        end
        m = m & 16'((1 << nbytes) - 1);
        return m[MAX_STRB-1:0];
    endfunction

endpackage

// File: rtl/apb_strb_gen.sv
// APB4 write-strobe decode from AHB size and low address bits; reads produce all-zero strobes.
// Latency: combinational.
// Backpressure: none; pure decode.
module apb_strb_gen
    import ahb_apb_pkg::*;
#(
    parameter int SZ = 64
) (
    input  logic [2:0]      size,
    input  logic [2:0]      addr_lsbs,
    input  logic            write,
    output logic [SZ/8-1:0] strb
);

    logic [MAX_STRB-1:0] full_mask;
    logic                unused_mask;

    assign full_mask   = strb_gen(size, addr_lsbs, SZ);
    // Upper lanes are always zero on a 32-bit bus; fold them away
    assign unused_mask = ^full_mask;
    assign strb        = write ? full_mask[SZ/8-1:0] : '0;

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB4 master bridge: one APB SETUP/ACCESS transfer per accepted AHB transfer.
// Latency: read data phase 3 cycles, write 4 cycles, plus one per APB cycle with PREADY low.
// Backpressure: HREADYOUT held low from acceptance until the APB slave signals PREADY in ACCESS.
module ahb_apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int SZ  = 64,
    parameter int PAW = 16
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic            HSEL,
    input  logic [31:0]     HADDR,
    input  logic [1:0]      HTRANS,
    input  logic            HWRITE,
    input  logic [2:0]      HSIZE,
    input  logic [SZ-1:0]   HWDATA,
    input  logic            HREADY,
    output logic            HREADYOUT,
    output logic [SZ-1:0]   HRDATA,
    output logic [PAW-1:0]  PADDR,
    output logic            PSEL,
    output logic            PENABLE,
    output logic            PWRITE,
    output logic [SZ-1:0]   PWDATA,
    output logic [SZ/8-1:0] PSTRB,
    input  logic [SZ-1:0]   PRDATA,
    input  logic            PREADY
);

    logic [3:0]      state;
    logic            accept;
    logic [SZ/8-1:0] strb_nxt;
    logic            unused_ahb;

    // Only bit 1 of HTRANS matters and upper address bits never reach APB
    assign unused_ahb = ^{HADDR[31:PAW], HTRANS[0]};

    // Address phase is only taken while idle, so the previous data phase is finished
    assign accept = (state == ST_IDLE) && HSEL && HTRANS[1] && HREADY;

    apb_strb_gen #(.SZ(SZ)) u_strb (
        .size      (HSIZE),
        .addr_lsbs (HADDR[2:0]),
        .write     (HWRITE),
        .strb      (strb_nxt)
    );

    // Transfer sequencing: writes take an extra cycle to pick up HWDATA
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (accept) state <= HWRITE ? ST_WDATA : ST_SETUP;
                ST_WDATA:  state <= ST_SETUP;
                ST_SETUP:  state <= ST_ACCESS;
                ST_ACCESS: if (PREADY) state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Capture the address-phase controls; held through the whole APB transfer
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PSTRB  <= '0;
        end else if (accept) begin
            PADDR  <= HADDR[PAW-1:0];
            PWRITE <= HWRITE;
            PSTRB  <= strb_nxt;
        end
    end

    // Write data arrives one cycle after the address phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            PWDATA <= '0;
        end else if (state == ST_WDATA) begin
            PWDATA <= HWDATA;
        end
    end

    // Read data is registered on APB completion and held until the next read completes
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HRDATA <= '0;
        end else if ((state == ST_ACCESS) && PREADY && !PWRITE) begin
            HRDATA <= PRDATA;
        end
    end

    assign HREADYOUT = (state == ST_IDLE);
    assign PSEL      = (state == ST_SETUP) || (state == ST_ACCESS);
    assign PENABLE   = (state == ST_ACCESS);

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Self-checking bench for ahb_apb_bridge: vector table of AHB transfers plus reset, idle and back-to-back sequences.
// Latency: n/a.
// Backpressure: APB slave model inserts a per-transfer number of PREADY-low ACCESS cycles.
module tb_ahb_apb_bridge;

    localparam int SZ  = 64;
    localparam int PAW = 16;

    logic            HCLK = 1'b0;
    logic            HRESETn;
    logic            HSEL;
    logic [31:0]     HADDR;
    logic [1:0]      HTRANS;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [SZ-1:0]   HWDATA;
    logic            HREADY;
    logic            HREADYOUT;
    logic [SZ-1:0]   HRDATA;
    logic [PAW-1:0]  PADDR;
    logic            PSEL;
    logic            PENABLE;
    logic            PWRITE;
    logic [SZ-1:0]   PWDATA;
    logic [SZ/8-1:0] PSTRB;
    logic [SZ-1:0]   PRDATA;
    logic            PREADY;

    // Single slave on the bus: bus-level ready follows this slave
    assign HREADY = HREADYOUT;

    ahb_apb_bridge #(.SZ(SZ), .PAW(PAW)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRDATA    (HRDATA),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          waits;
        logic [7:0]  strb;
        int          cycles;
    } vec_t;

    typedef struct {
        logic [15:0] paddr;
        logic        wr;
        logic [7:0]  strb;
        logic [63:0] wdata;
    } sb_t;

    sb_t         sb[$];
    vec_t        vecs[9];
    int          n_chk = 0;
    int          n_pass = 0;
    int          wait_cnt = 0;
    int          psel_run = 0;
    int          last_gap = 0;
    logic [63:0] prdata_v = '0;
    logic [63:0] last_rd = '0;

    assign PRDATA = prdata_v;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // APB slave model and scoreboard consumer, sampled on the falling edge
    initial begin
        PREADY = 1'b0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                PREADY   = 1'b0;
                psel_run = 0;
            end else begin
                if (PSEL && PENABLE) begin
                    if (wait_cnt > 0) begin
                        PREADY = 1'b0;
                        wait_cnt--;
                    end else begin
                        PREADY = 1'b1;
                    end
                    check("sb_depth", 64'(sb.size()), 64'd1);
                    if (sb.size() != 0) begin
                        check("paddr",  64'(PADDR),  64'(sb[0].paddr));
                        check("pwrite", 64'(PWRITE), 64'(sb[0].wr));
                        check("pstrb",  64'(PSTRB),  64'(sb[0].strb));
                        if (sb[0].wr) check("pwdata", PWDATA, sb[0].wdata);
                        if (PREADY) void'(sb.pop_front());
                    end
                end else begin
                    PREADY = 1'b0;
                end
                if (!PSEL) psel_run++;
                else if (psel_run > 0) begin
                    last_gap = psel_run;
                    psel_run = 0;
                end
            end
        end
    end

    // Drive one AHB transfer starting now (caller sits in an IDLE cycle) and
    // return at the falling edge where HREADYOUT comes back high.
    task automatic do_xfer(input vec_t v);
        int  cyc;
        bit  done;
        sb_t e;
        wait_cnt = v.waits;
        prdata_v = v.rdata;
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = v.addr;
        HWRITE = v.wr;
        HSIZE  = v.size;
        e.paddr = v.addr[15:0];
        e.wr    = v.wr;
        e.strb  = v.strb;
        e.wdata = v.wdata;
        sb.push_back(e);
        @(posedge HCLK);
        #1;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWDATA = v.wdata;
        cyc  = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge HCLK);
            cyc++;
            if (HREADYOUT || cyc >= 60) done = 1'b1;
        end
        check("data_phase_cycles", 64'(cyc), 64'(v.cycles));
        if (!v.wr) last_rd = v.rdata;
        check("hrdata", HRDATA, last_rd);
    endtask

    initial begin
        vec_t wv;
        vec_t rv;
        bit   seen;
        // wr, addr, size, wdata, rdata, waits, strb, data-phase cycles
        vecs[0] = '{1'b0, 32'h4000_0010, 3'd2, 64'h0, 64'hDEAD_BEEF_0123_4567, 0, 8'h00, 3};
        vecs[1] = '{1'b1, 32'h4000_0006, 3'd1, 64'h1122_3344_5566_7788, 64'h0, 0, 8'hC0, 4};
        vecs[2] = '{1'b1, 32'h4000_0103, 3'd0, 64'hA5A5_0000_FFFF_1234, 64'h0, 0, 8'h08, 4};
        vecs[3] = '{1'b1, 32'h0000_2005, 3'd2, 64'h0102_0304_0506_0708, 64'h0, 0, 8'hF0, 4};
        vecs[4] = '{1'b1, 32'h0000_0000, 3'd3, 64'hFFEE_DDCC_BBAA_9988, 64'h0, 0, 8'hFF, 4};
        vecs[5] = '{1'b1, 32'h0000_0009, 3'd4, 64'h1357_9BDF_2468_ACE0, 64'h0, 0, 8'hFF, 4};
        vecs[6] = '{1'b0, 32'h1234_ABC8, 3'd3, 64'h0, 64'h0F0E_0D0C_0B0A_0908, 2, 8'h00, 5};
        vecs[7] = '{1'b1, 32'h0000_FFFA, 3'd1, 64'hCAFE_F00D_8BAD_BEEF, 64'h0, 1, 8'h0C, 5};
        vecs[8] = '{1'b1, 32'h0000_0304, 3'd2, 64'h7766_5544_3322_1100, 64'h0, 3, 8'hF0, 7};

        HRESETn = 1'b0;
        HSEL    = 1'b0;
        HADDR   = '0;
        HTRANS  = 2'b00;
        HWRITE  = 1'b0;
        HSIZE   = 3'd0;
        HWDATA  = '0;
        repeat (3) @(negedge HCLK);

        // Reset values
        check("rst_hreadyout", 64'(HREADYOUT), 64'd1);
        check("rst_hrdata",    HRDATA,         64'd0);
        check("rst_paddr",     64'(PADDR),     64'd0);
        check("rst_psel",      64'(PSEL),      64'd0);
        check("rst_penable",   64'(PENABLE),   64'd0);
        check("rst_pwrite",    64'(PWRITE),    64'd0);
        check("rst_pwdata",    PWDATA,         64'd0);
        check("rst_pstrb",     64'(PSTRB),     64'd0);
        HRESETn = 1'b1;
        @(negedge HCLK);

        // BUSY transfers, then deselected NONSEQ transfers: nothing may start
        HSEL   = 1'b1;
        HTRANS = 2'b01;
        HADDR  = 32'h4000_0020;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                HSEL   = 1'b0;
                HTRANS = 2'b10;
            end
            @(negedge HCLK);
            check("idle_psel",      64'(PSEL),      64'd0);
            check("idle_hreadyout", 64'(HREADYOUT), 64'd1);
        end
        HTRANS = 2'b00;
        @(negedge HCLK);

        // Table-driven transfers with one idle cycle between them
        for (int i = 0; i < 9; i++) begin
            do_xfer(vecs[i]);
            @(negedge HCLK);
        end

        // Back-to-back write then read: read address taken in the IDLE cycle
        wv = '{1'b1, 32'h4000_0040, 3'd2, 64'h0BAD_CAFE_DEAD_10CC, 64'h0, 0, 8'h0F, 4};
        rv = '{1'b0, 32'h4000_0048, 3'd3, 64'h0, 64'h8877_6655_4433_2211, 0, 8'h00, 3};
        do_xfer(wv);
        last_gap = -1;
        do_xfer(rv);
        check("b2b_psel_gap", 64'(last_gap), 64'd1);
        @(negedge HCLK);

        // Reset asserted in the middle of a stalled ACCESS
        wait_cnt = 10;
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = 32'h0000_0080;
        HWRITE = 1'b1;
        HSIZE  = 3'd3;
        sb.push_back('{16'h0080, 1'b1, 8'hFF, 64'h5555_AAAA_5555_AAAA});
        @(posedge HCLK);
        #1;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWDATA = 64'h5555_AAAA_5555_AAAA;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge HCLK);
            if (PENABLE) seen = 1'b1;
        end
        check("mid_wait_access", 64'(PENABLE), 64'd1);
        @(negedge HCLK);
        #2;
        HRESETn = 1'b0;
        #1;
        check("mid_rst_psel",      64'(PSEL),      64'd0);
        check("mid_rst_penable",   64'(PENABLE),   64'd0);
        check("mid_rst_hreadyout", 64'(HREADYOUT), 64'd1);
        check("mid_rst_paddr",     64'(PADDR),     64'd0);
        check("mid_rst_pstrb",     64'(PSTRB),     64'd0);
        sb.delete();
        wait_cnt = 0;
        last_rd  = '0;
        repeat (2) @(negedge HCLK);
        check("mid_rst_hrdata", HRDATA, 64'd0);
        HRESETn = 1'b1;
        @(negedge HCLK);

        // Bridge resumes cleanly after the aborted transfer
        do_xfer(vecs[0]);
        @(negedge HCLK);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Watchdog so a stuck design cannot hang the run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
